// File: rtl/cc_random_selector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_random_selector_pkg
// Description : Shared encodings for the random row selector: mode values,
//               FSM state values and the maximal-length LFSR tap table.
// Revision    : 1.0  initial release
// ============================================================================
package cc_random_selector_pkg;

    // Mode select encodings
    localparam logic [1:0] MODE_RANDOM = 2'd0;
    localparam logic [1:0] MODE_NADA   = 2'd1;
    localparam logic [1:0] MODE_MIX    = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    // FSM state encodings
    localparam int         STATE_W = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEL  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Maximal-length Fibonacci tap masks (bit i set = register bit i feeds
    // the XOR). Width 8 uses bits 7,5,4,3 for a period of 255.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : cc_lfsr
// Description : Fibonacci LFSR, shift left, feedback into bit 0. Seed load
//               has priority over advance; a zero seed falls back to SEED.
// Revision    : 1.0  initial release
// ============================================================================
module cc_lfsr
    import cc_random_selector_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic             w_feedback;

    assign w_feedback = ^(lfsr_q & TAPS);

    // Next LFSR value: load beats advance; the all-zero lock-up state is
    // never allowed to be entered.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? SEED : seed_i;
        end else if (advance_i) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], w_feedback};
        end
        if (lfsr_d == '0) begin
            lfsr_d = SEED;
        end
    end

    // LFSR register with synchronous active-low reset to the seed
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/cc_random_selector.sv
`default_nettype none
// ============================================================================
// Module      : cc_random_selector
// Description : Request/ready row-word generator. A request in IDLE advances
//               the LFSR, SEL latches the mode-selected word and bit, WAIT
//               holds them valid until the consumer accepts.
// Revision    : 1.0  initial release
// ============================================================================
module cc_random_selector
    import cc_random_selector_pkg::*;
#(
    parameter int                      RS_DATAWIDTH   = 8,
    parameter int                      RS_SELECTWIDTH = 2,
    parameter logic [RS_DATAWIDTH-1:0] RS_SEED        = RS_DATAWIDTH'(8'hA5)
) (
    input  logic                            CC_RANDSEL_CLOCK_50,
    input  logic                            CC_RANDSEL_RESET_InLow,
    input  logic [RS_SELECTWIDTH-1:0]       CC_RANDSEL_select_InBUS,
    input  logic [RS_DATAWIDTH-1:0]         CC_RANDSEL_NADA_InBUS,
    input  logic [$clog2(RS_DATAWIDTH)-1:0] CC_RANDSEL_bitIndex_InBUS,
    input  logic                            CC_RANDSEL_seedLoad_In,
    input  logic [RS_DATAWIDTH-1:0]         CC_RANDSEL_seed_InBUS,
    input  logic                            CC_RANDSEL_request_In,
    input  logic                            CC_RANDSEL_ready_In,
    output logic [RS_DATAWIDTH-1:0]         CC_RANDSEL_RANDOM_OutBUS,
    output logic                            CC_RANDSEL_bit_Out,
    output logic                            CC_RANDSEL_valid_Out
);

    logic [STATE_W-1:0]      state_q;
    logic [STATE_W-1:0]      state_d;
    logic [RS_DATAWIDTH-1:0] word_q;
    logic [RS_DATAWIDTH-1:0] word_d;
    logic                    bit_q;
    logic                    bit_d;
    logic                    valid_q;
    logic                    valid_d;

    logic [RS_DATAWIDTH-1:0] w_lfsr;
    logic [RS_DATAWIDTH-1:0] w_sel_word;
    logic                    w_sel_bit;
    logic                    w_advance;

    // Only a request seen in IDLE steps the generator
    assign w_advance = (state_q == ST_IDLE) && CC_RANDSEL_request_In;

    cc_lfsr #(
        .WIDTH (RS_DATAWIDTH),
        .SEED  (RS_SEED)
    ) u_lfsr (
        .clk_i     (CC_RANDSEL_CLOCK_50),
        .rst_ni    (CC_RANDSEL_RESET_InLow),
        .load_i    (CC_RANDSEL_seedLoad_In),
        .seed_i    (CC_RANDSEL_seed_InBUS),
        .advance_i (w_advance),
        .value_o   (w_lfsr)
    );

    // Candidate word and bit for the SEL state; out-of-range index reads 0
    always_comb begin
        case (CC_RANDSEL_select_InBUS)
            RS_SELECTWIDTH'(MODE_RANDOM): w_sel_word = w_lfsr;
            RS_SELECTWIDTH'(MODE_NADA):   w_sel_word = CC_RANDSEL_NADA_InBUS;
            RS_SELECTWIDTH'(MODE_MIX):    w_sel_word = w_lfsr & CC_RANDSEL_NADA_InBUS;
            default:                      w_sel_word = word_q;
        endcase
        w_sel_bit = 1'b0;
        if (int'(CC_RANDSEL_bitIndex_InBUS) < RS_DATAWIDTH) begin
            w_sel_bit = w_sel_word[CC_RANDSEL_bitIndex_InBUS];
        end
    end

    // FSM state register
    always_ff @(posedge CC_RANDSEL_CLOCK_50) begin
        if (!CC_RANDSEL_RESET_InLow) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (CC_RANDSEL_request_In) state_d = ST_SEL;
            ST_SEL:  state_d = ST_WAIT;
            ST_WAIT: if (CC_RANDSEL_ready_In) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: load in SEL, hold in WAIT until accepted
    always_comb begin
        word_d  = word_q;
        bit_d   = bit_q;
        valid_d = valid_q;
        case (state_q)
            ST_SEL: begin
                word_d  = w_sel_word;
                bit_d   = w_sel_bit;
                valid_d = 1'b1;
            end
            ST_WAIT: if (CC_RANDSEL_ready_In) valid_d = 1'b0;
            default: valid_d = 1'b0;
        endcase
    end

    // Registered outputs
    always_ff @(posedge CC_RANDSEL_CLOCK_50) begin
        if (!CC_RANDSEL_RESET_InLow) begin
            word_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
        end
    end

    assign CC_RANDSEL_RANDOM_OutBUS = word_q;
    assign CC_RANDSEL_bit_Out       = bit_q;
    assign CC_RANDSEL_valid_Out     = valid_q;

endmodule
`default_nettype wire
